vending_mach: RTL and testbench
===============================

Name: vending_mach

Overview:
Single-clock, three-product vending controller for Lemonwater, Sodabottle and Waterbottle. It accepts Rs 5 and Rs 10 coins and tracks per-product stock. It dispenses the selected product with change, or refunds all inserted coins on cancel. It sits between the front-panel buttons/coin acceptor and the dispenser/refund mechanism.

Parameters:
PRICE_LEMON, 20, Lemonwater price in rupees
PRICE_SODA, 15, Sodabottle price in rupees
PRICE_WATER, 10, Waterbottle price in rupees

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
Fiverupee  input  1  Rs 5 coin inserted, one-cycle pulse
Tenrupee  input  1  Rs 10 coin inserted, one-cycle pulse
Lemonwater  input  1  select Lemonwater, pulse
Sodabottle  input  1  select Sodabottle, pulse
Waterbottle  input  1  select Waterbottle, pulse
cancel  input  1  abort transaction and refund
Lemonwater_added  input  5  Lemonwater stock loaded during reset
Sodabottle_added  input  5  Sodabottle stock loaded during reset
Waterbottle_added  input  5  Waterbottle stock loaded during reset
Lemonwater_available  output  5  current Lemonwater stock
Sodabottle_available  output  5  current Sodabottle stock
Waterbottle_available  output  5  current Waterbottle stock
coincount  output  5  rupees inserted in the current transaction
product  output  2  product code: 00 none, 01 Lemonwater, 10 Sodabottle, 11 Waterbottle
give  output  1  dispense strobe, one cycle
change  output  5  change or refund amount, valid for one cycle

Behaviour:
- One clock domain. reset is asynchronous and active-high.
- While reset=1:
  - state=IDLE; coincount, product, give and change are all 0.
  - On each rising clk edge, each stock register loads its *_added input. Reset must be held for at least one clock.
- Stock registers are 5-bit. They change only by reset load or by a decrement of 1 on dispense. *_available always equals the stock register.
- All outputs are registered.
- States: IDLE, COLLECT, DISPENSE, REFUND.
- IDLE:
  - product=00, coincount=0; coins and cancel are ignored.
  - A select pulse for a product with stock>0 latches that product code and moves to COLLECT.
  - Simultaneous selects resolve by priority Lemonwater > Sodabottle > Waterbottle.
  - A select for a product with stock=0 is ignored and the FSM stays in IDLE.
- COLLECT:
  - product shows the latched code; further selects are ignored.
  - Each clock, coincount += 5·Fiverupee + 10·Tenrupee (both high in one cycle adds 15).
  - If cancel=1 in that cycle, cancel wins and that cycle's coins are not counted. Next state REFUND.
  - If the updated coincount >= price, next state DISPENSE.
  - Worst case coincount is price-5+15 = 30, so it fits in 5 bits; no overflow is possible.
- DISPENSE (one cycle):
  - give=1, change=coincount-price, product holds its code.
  - Selected stock decrements by 1.
  - Next cycle: IDLE with coincount=0, product=00, give=0, change=0.
- REFUND (one cycle):
  - change=coincount, give=0, stock unchanged.
  - Next cycle: IDLE with coincount=0, product=00, change=0.
- Latency:
  - Select to COLLECT: 1 clock.
  - Final coin to give/change visible: 1 clock.
  - cancel to refund visible: 1 clock.
- Reset mid-transaction aborts immediately: inserted coins are discarded with no refund, and stock is reloaded from *_added.
- give and change are 0 in every state except as specified above.

Test Plan:
- Reset with Lemonwater_added=5, Sodabottle_added=3, Waterbottle_added=0 -> after reset: Lemonwater_available=5, Sodabottle_available=3, Waterbottle_available=0; coincount=0, product=00, give=0, change=0.
- Lemonwater pulse, then Tenrupee, then Fiverupee, then cancel -> product=01; coincount 10 then 15; one-cycle change=15 with give=0; back to IDLE with coincount=0; Lemonwater_available stays 5.
- Lemonwater pulse, Tenrupee, Tenrupee -> coincount reaches 20; give=1 one cycle, change=0, product=01; Lemonwater_available=4.
- Sodabottle pulse, Tenrupee, Tenrupee -> coincount 20 >= 15; give=1, change=5; Sodabottle_available decrements by 1.
- Waterbottle pulse with stock 0 -> stays IDLE, product=00; subsequent Tenrupee leaves coincount=0.
- In COLLECT with coincount=10, cancel together with Fiverupee -> refund change=10. Separately: reset asserted mid-COLLECT -> coincount=0 immediately and no change pulse.

Source files
------------

// File: rtl/vending_mach.sv
// Three-product vending controller: select a product, collect Rs 5/10 coins,
// then dispense with change or refund on cancel. Tracks per-product stock.
module vending_mach #(
  parameter int unsigned PRICE_LEMON = 20,
  parameter int unsigned PRICE_SODA  = 15,
  parameter int unsigned PRICE_WATER = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Fiverupee,
  input  logic       Tenrupee,
  input  logic       Lemonwater,
  input  logic       Sodabottle,
  input  logic       Waterbottle,
  input  logic       cancel,
  input  logic [4:0] Lemonwater_added,
  input  logic [4:0] Sodabottle_added,
  input  logic [4:0] Waterbottle_added,
  output logic [4:0] Lemonwater_available,
  output logic [4:0] Sodabottle_available,
  output logic [4:0] Waterbottle_available,
  output logic [4:0] coincount,
  output logic [1:0] product,
  output logic       give,
  output logic [4:0] change
);

  localparam logic [4:0] PriceLemon = 5'(PRICE_LEMON);
  localparam logic [4:0] PriceSoda  = 5'(PRICE_SODA);
  localparam logic [4:0] PriceWater = 5'(PRICE_WATER);

  localparam logic [1:0] ProdNone  = 2'b00;
  localparam logic [1:0] ProdLemon = 2'b01;
  localparam logic [1:0] ProdSoda  = 2'b10;
  localparam logic [1:0] ProdWater = 2'b11;

  typedef enum logic [1:0] {StIdle, StCollect, StDispense, StRefund} state_e;

  state_e     state_q, state_d;
  logic [4:0] coin_q, coin_d;
  logic [4:0] change_q, change_d;
  logic [1:0] prod_q, prod_d;
  logic       give_q, give_d;
  logic [4:0] coin_add, coin_sum, price_sel;
  logic [4:0] stock_lemon_q, stock_soda_q, stock_water_q;
  logic       dec_lemon, dec_soda, dec_water;

  // Price of the latched product and this cycle's coin credit.
  always_comb begin
    price_sel = 5'd0;
    case (prod_q)
      ProdLemon: price_sel = PriceLemon;
      ProdSoda:  price_sel = PriceSoda;
      ProdWater: price_sel = PriceWater;
      default:   price_sel = 5'd0;
    endcase
    coin_add = (Fiverupee ? 5'd5 : 5'd0) + (Tenrupee ? 5'd10 : 5'd0);
    coin_sum = coin_q + coin_add;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    coin_d    = coin_q;
    prod_d    = prod_q;
    give_d    = 1'b0;
    change_d  = 5'd0;
    dec_lemon = 1'b0;
    dec_soda  = 1'b0;
    dec_water = 1'b0;
    case (state_q)
      StIdle: begin
        coin_d = 5'd0;
        prod_d = ProdNone;
        // Selects for empty products drop out before priority resolution.
        if (Lemonwater && (stock_lemon_q != 5'd0)) begin
          prod_d  = ProdLemon;
          state_d = StCollect;
        end else if (Sodabottle && (stock_soda_q != 5'd0)) begin
          prod_d  = ProdSoda;
          state_d = StCollect;
        end else if (Waterbottle && (stock_water_q != 5'd0)) begin
          prod_d  = ProdWater;
          state_d = StCollect;
        end
      end
      StCollect: begin
        if (cancel) begin
          // Cancel wins over coins arriving in the same cycle.
          change_d = coin_q;
          state_d  = StRefund;
        end else begin
          coin_d = coin_sum;
          if (coin_sum >= price_sel) begin
            give_d    = 1'b1;
            change_d  = coin_sum - price_sel;
            state_d   = StDispense;
            dec_lemon = (prod_q == ProdLemon);
            dec_soda  = (prod_q == ProdSoda);
            dec_water = (prod_q == ProdWater);
          end
        end
      end
      StDispense, StRefund: begin
        state_d = StIdle;
        coin_d  = 5'd0;
        prod_d  = ProdNone;
      end
      default: begin
        state_d = StIdle;
        coin_d  = 5'd0;
        prod_d  = ProdNone;
      end
    endcase
  end

  // Transaction state and outputs; reset discards any coins without refund.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      coin_q   <= 5'd0;
      prod_q   <= ProdNone;
      give_q   <= 1'b0;
      change_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      coin_q   <= coin_d;
      prod_q   <= prod_d;
      give_q   <= give_d;
      change_q <= change_d;
    end
  end

  // Stock loads from *_added on every clock while reset is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      stock_lemon_q <= Lemonwater_added;
      stock_soda_q  <= Sodabottle_added;
      stock_water_q <= Waterbottle_added;
    end else begin
      if (dec_lemon) stock_lemon_q <= stock_lemon_q - 5'd1;
      if (dec_soda)  stock_soda_q  <= stock_soda_q - 5'd1;
      if (dec_water) stock_water_q <= stock_water_q - 5'd1;
    end
  end

  assign Lemonwater_available  = stock_lemon_q;
  assign Sodabottle_available  = stock_soda_q;
  assign Waterbottle_available = stock_water_q;
  assign coincount             = coin_q;
  assign product               = prod_q;
  assign give                  = give_q;
  assign change                = change_q;

endmodule

// File: tb/tb_vending_mach.sv
// Bench for vending_mach: directed vector table, reset corner cases and
// randomized traffic against a transaction-level reference model.
module tb_vending_mach;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       Fiverupee = 1'b0, Tenrupee = 1'b0;
  logic       Lemonwater = 1'b0, Sodabottle = 1'b0, Waterbottle = 1'b0, cancel = 1'b0;
  logic [4:0] Lemonwater_added = '0, Sodabottle_added = '0, Waterbottle_added = '0;
  logic [4:0] Lemonwater_available, Sodabottle_available, Waterbottle_available;
  logic [4:0] coincount, change;
  logic [1:0] product;
  logic       give;

  vending_mach dut (
    .clk                  (clk),
    .reset                (reset),
    .Fiverupee            (Fiverupee),
    .Tenrupee             (Tenrupee),
    .Lemonwater           (Lemonwater),
    .Sodabottle           (Sodabottle),
    .Waterbottle          (Waterbottle),
    .cancel               (cancel),
    .Lemonwater_added     (Lemonwater_added),
    .Sodabottle_added     (Sodabottle_added),
    .Waterbottle_added    (Waterbottle_added),
    .Lemonwater_available (Lemonwater_available),
    .Sodabottle_available (Sodabottle_available),
    .Waterbottle_available(Waterbottle_available),
    .coincount            (coincount),
    .product              (product),
    .give                 (give),
    .change               (change)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: one transaction at a time, credit in rupees.
  int price[3] = '{20, 15, 10};
  int stock[3];
  int m_prod, m_credit, m_give, m_change;
  bit m_fin;

  function automatic void model_clear();
    m_prod = 0; m_credit = 0; m_give = 0; m_change = 0; m_fin = 0;
  endfunction

  function automatic void model_step(input bit f, t, l, s, w, c);
    m_give = 0;
    m_change = 0;
    if (m_fin) begin
      model_clear();
    end else if (m_prod == 0) begin
      if (l && stock[0] > 0) m_prod = 1;
      else if (s && stock[1] > 0) m_prod = 2;
      else if (w && stock[2] > 0) m_prod = 3;
      m_credit = 0;
    end else if (c) begin
      m_change = m_credit;
      m_fin = 1;
    end else begin
      m_credit += 5 * int'(f) + 10 * int'(t);
      if (m_credit >= price[m_prod-1]) begin
        m_give = 1;
        m_change = m_credit - price[m_prod-1];
        stock[m_prod-1]--;
        m_fin = 1;
      end
    end
  endfunction

  task automatic apply(input bit f, t, l, s, w, c);
    Fiverupee = f; Tenrupee = t; Lemonwater = l; Sodabottle = s; Waterbottle = w; cancel = c;
    @(posedge clk);
    #1;
    model_step(f, t, l, s, w, c);
  endtask

  task automatic do_reset(input int a, input int b, input int w);
    Fiverupee = 0; Tenrupee = 0; Lemonwater = 0; Sodabottle = 0; Waterbottle = 0; cancel = 0;
    Lemonwater_added = 5'(a); Sodabottle_added = 5'(b); Waterbottle_added = 5'(w);
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    stock[0] = a; stock[1] = b; stock[2] = w;
    model_clear();
  endtask

  task automatic check_model(input string tag);
    check({tag, " coincount"}, int'(coincount), m_credit);
    check({tag, " product"}, int'(product), m_prod);
    check({tag, " give"}, int'(give), m_give);
    check({tag, " change"}, int'(change), m_change);
    check({tag, " lemon_avail"}, int'(Lemonwater_available), stock[0]);
    check({tag, " soda_avail"}, int'(Sodabottle_available), stock[1]);
    check({tag, " water_avail"}, int'(Waterbottle_available), stock[2]);
  endtask

  typedef struct {
    bit f, t, l, s, w, c;
    int coin, prod, give, change;
  } vec_t;

  vec_t vecs[19];

  initial begin
    // f t l s w c | coin prod give change (after the clock edge)
    vecs[0]  = '{0, 0, 1, 0, 0, 0,  0, 1, 0,  0};  // select lemon
    vecs[1]  = '{0, 1, 0, 0, 0, 0, 10, 1, 0,  0};
    vecs[2]  = '{1, 0, 0, 0, 0, 0, 15, 1, 0,  0};
    vecs[3]  = '{0, 0, 0, 0, 0, 1, 15, 1, 0, 15};  // refund 15
    vecs[4]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0,  0};
    vecs[5]  = '{0, 0, 1, 0, 0, 0,  0, 1, 0,  0};
    vecs[6]  = '{0, 1, 0, 0, 0, 0, 10, 1, 0,  0};
    vecs[7]  = '{0, 1, 0, 0, 0, 0, 20, 1, 1,  0};  // exact price
    vecs[8]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0,  0};
    vecs[9]  = '{0, 0, 0, 1, 0, 0,  0, 2, 0,  0};  // select soda
    vecs[10] = '{0, 1, 0, 0, 0, 0, 10, 2, 0,  0};
    vecs[11] = '{0, 1, 0, 0, 0, 0, 20, 2, 1,  5};  // change 5
    vecs[12] = '{0, 0, 0, 0, 0, 0,  0, 0, 0,  0};
    vecs[13] = '{0, 0, 0, 0, 1, 0,  0, 0, 0,  0};  // water empty
    vecs[14] = '{0, 1, 0, 0, 0, 0,  0, 0, 0,  0};  // coin ignored in idle
    vecs[15] = '{0, 0, 1, 0, 0, 0,  0, 1, 0,  0};
    vecs[16] = '{0, 1, 0, 0, 0, 0, 10, 1, 0,  0};
    vecs[17] = '{1, 0, 0, 0, 0, 1, 10, 1, 0, 10};  // cancel beats coin
    vecs[18] = '{0, 0, 0, 0, 0, 0,  0, 0, 0,  0};

    do_reset(5, 3, 0);
    check("rst lemon_avail", int'(Lemonwater_available), 5);
    check("rst soda_avail", int'(Sodabottle_available), 3);
    check("rst water_avail", int'(Waterbottle_available), 0);
    check("rst coincount", int'(coincount), 0);
    check("rst product", int'(product), 0);
    check("rst give", int'(give), 0);
    check("rst change", int'(change), 0);

    foreach (vecs[i]) begin
      apply(vecs[i].f, vecs[i].t, vecs[i].l, vecs[i].s, vecs[i].w, vecs[i].c);
      check($sformatf("vec%0d coincount", i), int'(coincount), vecs[i].coin);
      check($sformatf("vec%0d product", i), int'(product), vecs[i].prod);
      check($sformatf("vec%0d give", i), int'(give), vecs[i].give);
      check($sformatf("vec%0d change", i), int'(change), vecs[i].change);
      if (i == 4) check("lemon after refund", int'(Lemonwater_available), 5);
    end
    check("lemon after sale", int'(Lemonwater_available), 4);
    check("soda after sale", int'(Sodabottle_available), 2);
    check("water untouched", int'(Waterbottle_available), 0);

    // Both coins in one cycle add 15.
    do_reset(1, 1, 1);
    apply(0, 0, 0, 1, 0, 0);
    apply(1, 1, 0, 0, 0, 0);
    check("dual coin give", int'(give), 1);
    check("dual coin coincount", int'(coincount), 15);
    check("dual coin change", int'(change), 0);
    apply(0, 0, 0, 0, 0, 0);
    // Priority with an empty higher-priority product: soda now empty, water wins.
    apply(0, 0, 0, 1, 1, 0);
    check("priority fallthrough product", int'(product), 3);
    apply(0, 0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 0);

    // Reset mid-collect: coins discarded immediately, no refund, stock reloaded.
    do_reset(5, 5, 5);
    apply(0, 0, 1, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0);
    check("pre-reset coincount", int'(coincount), 10);
    Lemonwater_added = 5'd7; Sodabottle_added = 5'd6; Waterbottle_added = 5'd9;
    Tenrupee = 0;
    #2 reset = 1;
    #1;
    check("async rst coincount", int'(coincount), 0);
    check("async rst product", int'(product), 0);
    check("async rst change", int'(change), 0);
    check("async rst give", int'(give), 0);
    @(posedge clk);
    #1;
    check("reload lemon", int'(Lemonwater_available), 7);
    check("reload soda", int'(Sodabottle_available), 6);
    check("reload water", int'(Waterbottle_available), 9);
    reset = 0;
    stock[0] = 7; stock[1] = 6; stock[2] = 9;
    model_clear();
    apply(0, 0, 0, 0, 0, 0);
    check("no refund after rst", int'(change), 0);
    check("idle after rst coincount", int'(coincount), 0);

    // Randomized traffic against the model.
    for (int r = 0; r < 4; r++) begin
      do_reset($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      check_model($sformatf("rnd%0d reset", r));
      for (int k = 0; k < 500; k++) begin
        apply($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0);
        check_model($sformatf("rnd%0d cyc%0d", r, k));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
